// File: rtl/sc_spil_arb_pkg.sv
// sc_spil_arb_pkg: shared FSM states and field widths for the SPI Lite arbiter.
package sc_spil_arb_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;
  localparam int CSSEL_W = 5;
  localparam int DWIDTH_W = 9;
  localparam int DATA_W = 32;
endpackage

// File: rtl/sc_spil_rr_pick.sv
// sc_spil_rr_pick: combinational round-robin pick of the first valid index at or after ptr.
module sc_spil_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (valid[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/sc_spil_arbiter.sv
// sc_spil_arbiter: round-robin sharing of one SPI Lite engine between requesters,
// with CS-extended transaction locking and a hold timeout.
module sc_spil_arbiter
  import sc_spil_arb_pkg::*;
#(
  parameter int NUM_OF_REQ = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                           SYSCLK,
  input  logic                           SYSRSTB,
  input  logic [NUM_OF_REQ-1:0]          REQ_VALID,
  output logic [NUM_OF_REQ-1:0]          REQ_READY,
  input  logic [CSSEL_W*NUM_OF_REQ-1:0]  REQ_CSSEL,
  input  logic [DATA_W*NUM_OF_REQ-1:0]   REQ_TXDATA,
  input  logic [DWIDTH_W*NUM_OF_REQ-1:0] REQ_DWIDTH,
  input  logic [NUM_OF_REQ-1:0]          REQ_LAST,
  output logic [NUM_OF_REQ-1:0]          RSP_VALID,
  output logic [DATA_W-1:0]              RSP_RXDATA,
  output logic [NUM_OF_REQ-1:0]          GRANT,
  output logic                           TIMEOUT_ERR,
  output logic                           ENG_TXSTART,
  output logic [CSSEL_W-1:0]             ENG_CSSEL,
  output logic                           ENG_CSEXTEND,
  output logic [DATA_W-1:0]              ENG_TXDATA,
  output logic [DWIDTH_W-1:0]            ENG_DWIDTH,
  input  logic                           ENG_SPIBUSY,
  input  logic                           ENG_SPICOMPLETE,
  input  logic [DATA_W-1:0]              ENG_RXDATA
);
  localparam int IW = $clog2(NUM_OF_REQ);
  localparam int CW = $clog2(LOCK_TIMEOUT);

  state_t state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, owner, owner_nx, pick_idx;
  logic [NUM_OF_REQ-1:0] pick_gnt, own_hot, req_ready;
  logic [CW-1:0] cnt;
  logic last, accept, done, timeout, txstart;

  sc_spil_rr_pick #(.N(NUM_OF_REQ), .IW(IW)) u_pick (
    .valid(REQ_VALID),
    .ptr(ptr),
    .grant(pick_gnt),
    .idx(pick_idx)
  );

  assign own_hot = NUM_OF_REQ'(1) << owner;
  assign ptr_nx = (owner == IW'(NUM_OF_REQ - 1)) ? '0 : owner + 1'b1;
  assign accept = |req_ready;
  assign REQ_READY = SYSRSTB ? req_ready : '0;
  assign ENG_TXSTART = SYSRSTB & txstart;
  assign GRANT = (state == IDLE) ? '0 : own_hot;
  assign ENG_CSEXTEND = (state != IDLE) && !last;

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    req_ready = '0;
    txstart = 1'b0;
    done = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: if (|REQ_VALID) begin
        req_ready = pick_gnt;
        owner_nx = pick_idx;
        state_nx = START;
      end
      START: if (!ENG_SPIBUSY) begin
        txstart = 1'b1;
        state_nx = WAIT;
      end
      WAIT: if (ENG_SPICOMPLETE) begin
        done = 1'b1;
        state_nx = last ? IDLE : HOLD;
      end
      HOLD: if (REQ_VALID[owner]) begin
        req_ready = own_hot;
        state_nx = START;
      end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
        timeout = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (!SYSRSTB) begin
      state <= IDLE;
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
      last <= 1'b0;
      ENG_CSSEL <= '0;
      ENG_TXDATA <= '0;
      ENG_DWIDTH <= '0;
      RSP_VALID <= '0;
      RSP_RXDATA <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      cnt <= (state == HOLD) ? cnt + 1'b1 : '0;
      RSP_VALID <= done ? own_hot : '0;
      TIMEOUT_ERR <= timeout;
      if (accept) begin
        ENG_CSSEL <= REQ_CSSEL[owner_nx*CSSEL_W +: CSSEL_W];
        ENG_TXDATA <= REQ_TXDATA[owner_nx*DATA_W +: DATA_W];
        ENG_DWIDTH <= REQ_DWIDTH[owner_nx*DWIDTH_W +: DWIDTH_W];
        last <= REQ_LAST[owner_nx];
      end
      if (done) RSP_RXDATA <= ENG_RXDATA;
      if ((done && last) || timeout) ptr <= ptr_nx;
    end
  end
endmodule
